// File: rtl/dm_responder.sv
`default_nettype none
// ------------------------------------------------------------------------
// dm_responder : two-cycle M-stage data responder (RAM + countdown timer)
// Revision     : 1.0
// ------------------------------------------------------------------------
module dm_responder #(
    parameter int          MEM_WORDS  = 3072,
    parameter logic [31:0] TIMER_BASE = 32'h0000_7F00
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        WE,
    input  logic [3:0]  BE,
    input  logic [31:0] Addr,
    input  logic [31:0] WD,
    output logic        Ready,
    output logic [31:0] RD,
    output logic        Err,
    output logic        IRQ
);
    localparam int          AW        = $clog2(MEM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS) << 2;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RESP = 1'b1;

    localparam logic [1:0] T_IDLE = 2'd0;
    localparam logic [1:0] T_LOAD = 2'd1;
    localparam logic [1:0] T_CNT  = 2'd2;
    localparam logic [1:0] T_INT  = 2'd3;

    logic [0:0]    state_q, state_d;
    logic [1:0]    tstate_q, tstate_d;
    logic [31:0]   mem_q [MEM_WORDS];
    logic [31:0]   rd_q, rd_d;
    logic          err_q, err_d;
    logic [3:0]    ctrl_q;
    logic [31:0]   preset_q, count_q;
    logic          irq_latch_q;

    logic          accept, fault, is_ram, is_ctrl, is_pre, is_cnt;
    logic          ram_we, ctrl_we, pre_we;
    logic [31:0]   rdata, bmask;
    logic [AW-1:0] widx;
    logic          en, auto_mode, cnt_load, cnt_dec, os_fire;

    assign widx    = Addr[AW+1:2];
    assign is_ram  = Addr < RAM_BYTES;
    assign is_ctrl = Addr == TIMER_BASE;
    assign is_pre  = Addr == TIMER_BASE + 32'd4;
    assign is_cnt  = Addr == TIMER_BASE + 32'd8;
    assign bmask   = {{8{BE[3]}}, {8{BE[2]}}, {8{BE[1]}}, {8{BE[0]}}};
    assign accept  = (state_q == S_IDLE) && Req;

    // Decode in priority order; a fault forces RD to zero and suppresses writes.
    always_comb begin
        fault = 1'b1;
        rdata = '0;
        if (Addr[1:0] == 2'b00) begin
            if (is_ram) begin
                fault = 1'b0;
                rdata = WE ? 32'd0 : mem_q[widx];
            end else if (is_ctrl || is_pre) begin
                fault = WE && (BE != 4'hF);
                rdata = WE ? 32'd0 : (is_ctrl ? {28'd0, ctrl_q} : preset_q);
            end else if (is_cnt) begin
                fault = WE;
                rdata = WE ? 32'd0 : count_q;
            end
        end
        if (fault) rdata = '0;
    end

    assign ram_we  = accept && WE && !fault && is_ram;
    assign ctrl_we = accept && WE && !fault && is_ctrl;
    assign pre_we  = accept && WE && !fault && is_pre;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (Req) state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        Ready = (state_q == S_RESP);
        RD    = rd_q;
        Err   = err_q;
        rd_d  = accept ? rdata : 32'd0;
        err_d = accept && fault;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            rd_q  <= rd_d;
            err_q <= err_d;
        end
    end

    for (genvar gi = 0; gi < MEM_WORDS; gi++) begin : g_word
        always_ff @(posedge Clk or negedge Reset) begin
            if (!Reset)
                mem_q[gi] <= '0;
            else if (ram_we && (widx == AW'(gi)))
                mem_q[gi] <= (mem_q[gi] & ~bmask) | (WD & bmask);
        end
    end

    assign en        = ctrl_q[0];
    assign auto_mode = (ctrl_q[2:1] == 2'b01);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) tstate_q <= T_IDLE;
        else        tstate_q <= tstate_d;
    end

    // Entering T_INT on the edge that makes COUNT zero gives IRQ at PRESET+2.
    always_comb begin
        tstate_d = tstate_q;
        case (tstate_q)
            T_IDLE: if (en) tstate_d = T_LOAD;
            T_LOAD: begin
                if (!en)                  tstate_d = T_IDLE;
                else if (preset_q == '0)  tstate_d = T_INT;
                else                      tstate_d = T_CNT;
            end
            T_CNT: begin
                if (!en)                                  tstate_d = T_IDLE;
                else if (count_q == 32'd0 || count_q == 32'd1) tstate_d = T_INT;
            end
            default: tstate_d = (auto_mode && en) ? T_LOAD : T_IDLE;
        endcase
    end

    always_comb begin
        cnt_load = (tstate_q == T_LOAD) && en;
        cnt_dec  = (tstate_q == T_CNT) && en && (count_q != 32'd0);
        os_fire  = (tstate_q == T_INT) && !auto_mode;
        IRQ      = irq_latch_q || ((tstate_q == T_INT) && ctrl_q[3]);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ctrl_q      <= '0;
            preset_q    <= '0;
            count_q     <= '0;
            irq_latch_q <= 1'b0;
        end else begin
            if (ctrl_we) begin
                ctrl_q      <= WD[3:0];
                irq_latch_q <= 1'b0;
            end else if (os_fire) begin
                ctrl_q[0] <= 1'b0;
                if (ctrl_q[3]) irq_latch_q <= 1'b1;
            end
            if (pre_we) preset_q <= WD;
            if (cnt_load)     count_q <= preset_q;
            else if (cnt_dec) count_q <= count_q - 32'd1;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dm_responder.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_dm_responder : randomized self-checking bench with reference model
// Revision        : 1.0
// ------------------------------------------------------------------------
module tb_dm_responder;
    localparam int          MW = 3072;
    localparam logic [31:0] TB = 32'h0000_7F00;

    logic        Clk = 1'b0, Reset = 1'b0, Req = 1'b0, WE = 1'b0;
    logic [3:0]  BE = '0;
    logic [31:0] Addr = '0, WD = '0;
    logic        Ready, Err, IRQ;
    logic [31:0] RD;

    int total = 0, bad = 0, cyc = 0, last_acc = 0;
    logic [31:0] ref_mem [int];

    dm_responder #(.MEM_WORDS(MW), .TIMER_BASE(TB)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .WE(WE), .BE(BE), .Addr(Addr),
        .WD(WD), .Ready(Ready), .RD(RD), .Err(Err), .IRQ(IRQ)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_get(input int idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : 32'd0;
    endfunction

    // Reference COUNT after the d-th edge following an auto-reload enable.
    function automatic logic [31:0] auto_count(input int n, input int d);
        int j;
        j = (d - 2) % (n + 2);
        return (j <= n) ? 32'(n - j) : 32'd0;
    endfunction

    task automatic xfer(input string tag, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
        @(negedge Clk);
        Req = 1'b1; WE = we; BE = be; Addr = addr; WD = wd;
        @(posedge Clk); #1;
        last_acc = cyc;
        chk($sformatf("%s rdy", tag), 32'(Ready), 32'd1);
        chk($sformatf("%s rd", tag), RD, exp_rd);
        chk($sformatf("%s err", tag), 32'(Err), 32'(exp_err));
        Req = 1'b0;
        @(posedge Clk); #1;
        chk($sformatf("%s rdy_low", tag), 32'(Ready), 32'd0);
    endtask

    task automatic ram_store(input string tag, input int idx, input logic [3:0] be, input logic [31:0] wd);
        logic [31:0] w;
        w = mem_get(idx);
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
        ref_mem[idx] = w;
        xfer(tag, 1'b1, be, 32'(idx) << 2, wd, 32'd0, 1'b0);
    endtask

    task automatic run_auto(input int n, input string tag);
        int t0, d, e;
        logic [31:0] fz;
        xfer({tag, " preset"}, 1'b1, 4'hF, TB + 32'd4, 32'(n), 32'd0, 1'b0);
        xfer({tag, " ctrl"}, 1'b1, 4'hF, TB, 32'hB, 32'd0, 1'b0);
        t0 = last_acc;
        for (int k = 0; k < 3 * (n + 2); k++) begin
            @(posedge Clk); #1;
            d = cyc - t0;
            chk($sformatf("%s irq d=%0d", tag, d), 32'(IRQ), 32'(((d - 2) % (n + 2)) == n));
        end
        xfer({tag, " stop"}, 1'b1, 4'hF, TB, 32'hA, 32'd0, 1'b0);
        e  = last_acc;
        fz = auto_count(n, e - t0);
        xfer({tag, " frz1"}, 1'b0, 4'h0, TB + 32'd8, 32'd0, fz, 1'b0);
        xfer({tag, " frz2"}, 1'b0, 4'h0, TB + 32'd8, 32'd0, fz, 1'b0);
        xfer({tag, " clr"}, 1'b1, 4'hF, TB, 32'h0, 32'd0, 1'b0);
    endtask

    initial begin
        int          idx, t0, d;
        logic        we, mis;
        logic [3:0]  be;
        logic [31:0] addr, wd, exp_rd;

        repeat (2) @(posedge Clk);
        #1;
        chk("rst ready", 32'(Ready), 32'd0);
        chk("rst rd", RD, 32'd0);
        chk("rst err", 32'(Err), 32'd0);
        chk("rst irq", 32'(IRQ), 32'd0);
        @(negedge Clk); Reset = 1'b1;

        ram_store("st10", 4, 4'hF, 32'hDEADBEEF);
        xfer("ld10", 1'b0, 4'h0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);
        ram_store("stbe", 4, 4'b0100, 32'h00AA0000);
        xfer("ldbe", 1'b0, 4'h0, 32'h10, 32'd0, 32'hDEAABEEF, 1'b0);

        xfer("mis", 1'b0, 4'h0, 32'h13, 32'd0, 32'd0, 1'b1);
        xfer("st_cnt", 1'b1, 4'hF, TB + 32'd8, $urandom, 32'd0, 1'b1);
        xfer("ld_cnt", 1'b0, 4'h0, TB + 32'd8, 32'd0, 32'd0, 1'b0);
        xfer("ramend", 1'b0, 4'h0, 32'(MW) << 2, 32'd0, 32'd0, 1'b1);
        xfer("ctrl_be", 1'b1, 4'b0111, TB, 32'hF, 32'd0, 1'b1);
        xfer("ctrl_rd", 1'b0, 4'h0, TB, 32'd0, 32'd0, 1'b0);
        xfer("unmap", 1'b0, 4'h0, 32'h8000, 32'd0, 32'd0, 1'b1);

        @(negedge Clk);
        Req = 1'b1; WE = 1'b0; BE = 4'h0; Addr = 32'h10;
        for (int k = 0; k < 4; k++) begin
            @(posedge Clk); #1;
            chk($sformatf("hold rdy k=%0d", k), 32'(Ready), 32'(k % 2 == 0));
            if (k % 2 == 0) chk($sformatf("hold rd k=%0d", k), RD, 32'hDEAABEEF);
        end
        Req = 1'b0;

        for (int i = 0; i < 40; i++) begin
            idx = ($urandom_range(0, 7) == 0) ? MW - 1 : int'($urandom_range(0, 15));
            mis = ($urandom_range(0, 9) == 0);
            we  = 1'($urandom_range(0, 1));
            be  = 4'($urandom);
            wd  = $urandom;
            addr = (32'(idx) << 2) | (mis ? 32'($urandom_range(1, 3)) : 32'd0);
            if (mis)
                xfer($sformatf("rnd%0d mis", i), we, be, addr, wd, 32'd0, 1'b1);
            else if (we)
                ram_store($sformatf("rnd%0d st", i), idx, be, wd);
            else begin
                exp_rd = mem_get(idx);
                xfer($sformatf("rnd%0d ld", i), 1'b0, be, addr, 32'd0, exp_rd, 1'b0);
            end
        end

        xfer("os preset", 1'b1, 4'hF, TB + 32'd4, 32'd5, 32'd0, 1'b0);
        xfer("os ctrl", 1'b1, 4'hF, TB, 32'h9, 32'd0, 1'b0);
        t0 = last_acc;
        for (int k = 0; k < 11; k++) begin
            @(posedge Clk); #1;
            d = cyc - t0;
            chk($sformatf("os irq d=%0d", d), 32'(IRQ), 32'(d >= 7));
        end
        xfer("os ctrl_rd", 1'b0, 4'h0, TB, 32'd0, 32'h8, 1'b0);
        chk("os irq held", 32'(IRQ), 32'd1);
        xfer("os clr", 1'b1, 4'hF, TB, 32'h0, 32'd0, 1'b0);
        chk("os irq clr", 32'(IRQ), 32'd0);

        run_auto(3, "ar3");
        run_auto(int'($urandom_range(0, 6)), "arR");

        @(negedge Clk);
        Req = 1'b1; WE = 1'b0; BE = 4'h0; Addr = 32'h10;
        @(posedge Clk); #1;
        chk("rma rdy", 32'(Ready), 32'd1);
        Req = 1'b0;
        Reset = 1'b0;
        #1;
        chk("rma ready", 32'(Ready), 32'd0);
        chk("rma rd", RD, 32'd0);
        chk("rma err", 32'(Err), 32'd0);
        chk("rma irq", 32'(IRQ), 32'd0);
        @(negedge Clk); Reset = 1'b1;
        ref_mem.delete();
        xfer("post ld10", 1'b0, 4'h0, 32'h10, 32'd0, 32'd0, 1'b0);
        xfer("post ldlast", 1'b0, 4'h0, 32'(MW - 1) << 2, 32'd0, 32'd0, 1'b0);
        xfer("post preset", 1'b0, 4'h0, TB + 32'd4, 32'd0, 32'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
